// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit CLA multi-precision sequencer.
//   BYTE_W      : byte width of every adder beat
//   ST_IDLE/RUN : sequencer state encodings
//   cnt_w()     : byte-counter width for a given operand byte count
//   out_beat_t  : payload held by the output stage
package alu_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Counter width for n bytes; n is at least 2, so the result is at least 1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n);
  endfunction

  typedef struct packed {
    logic [BYTE_W-1:0] sum;
    logic              last;
    logic              cout;
    logic              z;
    logic              v;
  } out_beat_t;

endpackage

// File: rtl/cla8.sv
// 8-bit carry-lookahead adder (combinational).
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, low 8 bits
//   cout : carry out of bit 7
module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Generate/propagate carry recurrence, flattened into lookahead terms by synthesis.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/cla8_out_stage.sv
// One-entry output register with valid/ready handshake.
//   load  : capture d (caller guarantees the slot is empty or draining)
//   ready : downstream accepts the held beat
//   valid : a beat is held
//   q     : held beat payload
module cla8_out_stage
  import alu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      ready,
  input  out_beat_t d,
  output logic      valid,
  output out_beat_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cla8_mp_seq.sv
// Multi-precision add/sub sequencer around an external 8-bit CLA.
// Operands arrive as byte pairs, LSB first; the adder carry is chained
// between beats and each result byte is registered with end-of-op flags.
// Optional feature macro: CLA_SUB_EN (adds in_sub port, enables A-B).
//   in_valid/in_ready/in_A/in_B[/in_sub] : input byte-pair stream
//   add_A/add_B/add_Cin -> adder, add_Sum/add_Cout <- adder (same cycle)
//   out_valid/out_ready/out_Sum/out_last : result byte stream
//   out_Cout/out_Z/out_V                 : flags, valid with out_last
module cla8_mp_seq
  import alu_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_A,
  input  logic [BYTE_W-1:0] in_B,
`ifdef CLA_SUB_EN
  input  logic              in_sub,
`endif
  output logic [BYTE_W-1:0] add_A,
  output logic [BYTE_W-1:0] add_B,
  output logic              add_Cin,
  input  logic [BYTE_W-1:0] add_Sum,
  input  logic              add_Cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_Sum,
  output logic              out_last,
  output logic              out_Cout,
  output logic              out_Z,
  output logic              out_V
);

  localparam int unsigned CNT_W = cnt_w(NBYTES);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;
  logic             accept, first, last, sub_now, z_run;
  out_beat_t        beat, held;

  // Operation type: taken live on byte 0, from the latched copy afterwards.
`ifdef CLA_SUB_EN
  logic op_sub_q, op_sub_d;
  assign sub_now = first ? in_sub : op_sub_q;
`else
  assign sub_now = 1'b0;
`endif

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign first    = (state_q == ST_IDLE);
  assign last     = (state_q == ST_RUN) && (cnt_q == CNT_W'(NBYTES - 1));

  assign add_A   = in_A;
  assign add_B   = sub_now ? ~in_B : in_B;
  assign add_Cin = first ? sub_now : carry_q;

  // Running zero flag restarts on byte 0.
  assign z_run = (add_Sum == '0) & (first | zacc_q);

  always_comb begin
    beat      = '0;
    beat.sum  = add_Sum;
    beat.last = last;
    beat.cout = last & add_Cout;
    beat.z    = last & z_run;
    beat.v    = last & (in_A[BYTE_W-1] == add_B[BYTE_W-1]) & (add_Sum[BYTE_W-1] != in_A[BYTE_W-1]);
  end

  // Next-state: only accepted beats advance the sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
`ifdef CLA_SUB_EN
    op_sub_d = op_sub_q;
    if (accept && first) op_sub_d = in_sub;
`endif
    if (accept) begin
      carry_d = add_Cout;
      zacc_d  = z_run;
      if (last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ST_RUN;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
`ifdef CLA_SUB_EN
      op_sub_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
`ifdef CLA_SUB_EN
      op_sub_q <= op_sub_d;
`endif
    end
  end

  cla8_out_stage u_out (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .ready (out_ready),
    .d     (beat),
    .valid (out_valid),
    .q     (held)
  );

  assign out_Sum  = held.sum;
  assign out_last = held.last;
  assign out_Cout = held.cout;
  assign out_Z    = held.z;
  assign out_V    = held.v;

endmodule

// File: tb/tb_cla8_mp_seq.sv
// Bench for cla8_mp_seq (NBYTES=4) with the cla8 adder attached.
module tb_cla8_mp_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_A, in_B;
  logic       in_sub;
  logic [7:0] add_A, add_B, add_Sum;
  logic       add_Cin, add_Cout;
  logic       out_valid, out_ready;
  logic [7:0] out_Sum;
  logic       out_last, out_Cout, out_Z, out_V;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla8_mp_seq #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_A(in_A), .in_B(in_B),
`ifdef CLA_SUB_EN
    .in_sub(in_sub),
`endif
    .add_A(add_A), .add_B(add_B), .add_Cin(add_Cin),
    .add_Sum(add_Sum), .add_Cout(add_Cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_Sum(out_Sum),
    .out_last(out_last), .out_Cout(out_Cout), .out_Z(out_Z), .out_V(out_V)
  );

  cla8 u_add (.a(add_A), .b(add_B), .cin(add_Cin), .sum(add_Sum), .cout(add_Cout));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        v;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive `n` beats of one op with out_ready=1; each beat must appear one cycle later.
  task automatic run_vec(input vec_t t, input int n, input string nm);
    logic        lst;
    logic [31:0] exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_A     = t.a[8*i +: 8];
      in_B     = t.b[8*i +: 8];
      in_sub   = (i == 0) ? t.sub : ~t.sub;
      @(posedge clk);
      #1;
      lst = (i == 3);
      exp = {19'd0, 1'b1, t.res[8*i +: 8], lst, t.c & lst, t.z & lst, t.v & lst};
      chk($sformatf("%s_b%0d {vld,sum,last,c,z,v}", nm, i),
          {19'd0, out_valid, out_Sum, out_last, out_Cout, out_Z, out_V}, exp);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Two back-to-back ops streamed with a 3-cycle downstream stall mid-op.
  task automatic run_stream();
    logic [31:0] opa[2], opb[2], res[2];
    logic        fc[2];
    logic [7:0]  held;
    logic        have_hold, acc, lst;
    int          ii, oi;
    opa[0] = 32'h04030201; opb[0] = 32'h10101010; res[0] = 32'h14131211; fc[0] = 1'b0;
    opa[1] = 32'hFFFFFFFF; opb[1] = 32'hFFFFFFFF; res[1] = 32'hFFFFFFFE; fc[1] = 1'b1;
    ii = 0; oi = 0; have_hold = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && oi < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc < 6);
      in_valid  = (ii < 8);
      in_sub    = 1'b0;
      if (ii < 8) begin
        in_A = opa[ii/4][8*(ii%4) +: 8];
        in_B = opb[ii/4][8*(ii%4) +: 8];
      end
      #1;
      acc = in_valid & in_ready;
      if (out_valid && !out_ready) begin
        chk($sformatf("stall_in_ready_c%0d", cyc), {31'd0, in_ready}, 32'd0);
        if (have_hold) chk($sformatf("stall_hold_c%0d", cyc), {24'd0, out_Sum}, {24'd0, held});
        have_hold = 1'b1;
        held      = out_Sum;
      end else begin
        have_hold = 1'b0;
      end
      if (out_valid && out_ready) begin
        lst = (oi % 4 == 3);
        chk($sformatf("stream_byte%0d {sum,last,c,z,v}", oi),
            {20'd0, out_Sum, out_last, out_Cout, out_Z, out_V},
            {20'd0, res[oi/4][8*(oi%4) +: 8], lst, fc[oi/4] & lst, 1'b0, 1'b0});
        oi++;
      end
      @(posedge clk);
      if (acc) ii++;
    end
    chk("stream_bytes_delivered", oi, 32'd8);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_A = '0; in_B = '0; in_sub = 1'b0; out_ready = 1'b1;
    #1;
    chk("reset {vld,sum,last,c,z,v}",
        {19'd0, out_valid, out_Sum, out_last, out_Cout, out_Z, out_V}, 32'd0);
    chk("reset_add_cin", {31'd0, add_Cin}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0});
`ifdef CLA_SUB_EN
    vecs.push_back('{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0});
`endif

    foreach (vecs[k]) run_vec(vecs[k], 4, $sformatf("vec%0d", k));

    // Idle bus: adder inputs still track in_A/in_B.
    @(negedge clk);
    in_A = 8'h5A; in_B = 8'h3C;
    #1;
    chk("idle_add_A", {24'd0, add_A}, 32'h5A);
    chk("idle_add_cin", {31'd0, add_Cin}, 32'd0);

    run_stream();

    // Reset after two beats: pending output dropped, next op starts at byte 0.
    run_vec('{32'hAAAAAAAA, 32'h11111111, 1'b0, 32'hBBBBBBBB, 1'b0, 1'b0, 1'b0}, 2, "pre_rst");
    rst = 1'b1;
    #1;
    chk("midop_reset {vld,sum,last}", {22'd0, out_valid, out_Sum, out_last}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec('{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0}, 4, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
